// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ valid/ready producers, granting each owner a burst of up to
// BURST_MAX accepted beats.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous reset, active-low
//   i_req_valid    per-requester data valid
//   i_req_data     packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready    per-requester accept strobe (combinational)
//   i_fifo_full    FIFO full flag
//   o_fifo_wr      FIFO write enable (combinational)
//   o_fifo_data    FIFO write data, owner payload in GRANT, 0 otherwise
//   o_grant_id     current owner (registered)
//   o_busy         high while in GRANT
//   o_stat_cnt     per-requester 16-bit saturating accepted-beat counts
//                  (present only when FIFO_ARB_STATS_EN is defined)
//
// Optional feature macro: FIFO_ARB_STATS_EN

module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned REQ_ID_WIDTH = 2,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned BURST_MAX    = 4,
   parameter int unsigned BURST_WIDTH  = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic                          i_fifo_full,
   output logic                          o_fifo_wr,
   output logic [DATA_WIDTH-1:0]         o_fifo_data,
   output logic [REQ_ID_WIDTH-1:0]       o_grant_id,
   output logic                          o_busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]         o_stat_cnt
`endif
);

   localparam int unsigned STAT_WIDTH = 16;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [REQ_ID_WIDTH-1:0]  r_owner;
   logic [REQ_ID_WIDTH-1:0]  r_rr_ptr;
   logic [BURST_WIDTH-1:0]   r_beat_cnt;

   logic                     w_any_valid;
   logic                     w_found;
   logic [REQ_ID_WIDTH-1:0]  w_idx;
   logic [REQ_ID_WIDTH-1:0]  w_sel;
   logic                     w_owner_valid;
   logic [DATA_WIDTH-1:0]    w_owner_data;
   logic                     w_accept;
   logic                     w_last;
   logic                     w_release;

   // Round-robin pick: first valid requester at or after r_rr_ptr, wrapping.
   always_comb begin
      w_any_valid = |i_req_valid;
      w_found     = 1'b0;
      w_sel       = r_rr_ptr;
      w_idx       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx = r_rr_ptr + REQ_ID_WIDTH'(k);
         if (!w_found && i_req_valid[w_idx]) begin
            w_sel   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   // Owner handshake and burst release conditions.
   always_comb begin
      w_owner_valid = i_req_valid[r_owner];
      w_owner_data  = i_req_data[32'(r_owner) * DATA_WIDTH +: DATA_WIDTH];
      w_accept      = (r_state == S_GRANT) && w_owner_valid && !i_fifo_full;
      w_last        = (r_beat_cnt == BURST_WIDTH'(BURST_MAX - 1));
      w_release     = (r_state == S_GRANT) && ((w_accept && w_last) || !w_owner_valid);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any_valid) w_state_nxt = S_GRANT;
         S_GRANT: if (w_release)   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic: zero-cycle path from owner valid/full to the write strobe.
   always_comb begin
      o_fifo_wr   = 1'b0;
      o_req_ready = '0;
      o_fifo_data = '0;
      if (r_state == S_GRANT) begin
         o_fifo_data          = w_owner_data;
         o_fifo_wr            = w_accept;
         o_req_ready[r_owner] = w_accept;
      end
   end

   // Owner, beat counter and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_owner    <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         if (r_state == S_IDLE && w_any_valid) begin
            r_owner    <= w_sel;
            r_beat_cnt <= '0;
         end
         if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + BURST_WIDTH'(1);
         end
         // Just-served requester drops to lowest priority.
         if (w_release) begin
            r_rr_ptr <= r_owner + REQ_ID_WIDTH'(1);
         end
      end
   end

   assign o_grant_id = r_owner;
   assign o_busy     = (r_state == S_GRANT);

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_WIDTH-1:0] r_stat [NUM_REQ];

   // Per-requester saturating counts of accepted beats.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            r_stat[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (o_req_ready[i] && (r_stat[i] != {STAT_WIDTH{1'b1}})) begin
               r_stat[i] <= r_stat[i] + STAT_WIDTH'(1);
            end
         end
      end
   end

   always_comb begin
      o_stat_cnt = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         o_stat_cnt[i*STAT_WIDTH +: STAT_WIDTH] = r_stat[i];
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter.
// Producers are modelled as beat counters that hold valid/data until ready.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.

module tb_fifo_wr_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned DW      = 32;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*DW-1:0]   req_data;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    fifo_full;
   logic                    fifo_wr;
   logic [DW-1:0]           fifo_data;
   logic [1:0]              grant_id;
   logic                    busy;
`ifdef FIFO_ARB_STATS_EN
   logic [NUM_REQ*16-1:0]   stat_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   int rem  [NUM_REQ];
   int sent [NUM_REQ];
   int wr_count = 0;
   int wr_mark;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ(4), .REQ_ID_WIDTH(2), .DATA_WIDTH(32), .BURST_MAX(4), .BURST_WIDTH(3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .o_req_ready (req_ready),
      .i_fifo_full (fifo_full),
      .o_fifo_wr   (fifo_wr),
      .o_fifo_data (fifo_data),
      .o_grant_id  (grant_id),
      .o_busy      (busy)
`ifdef FIFO_ARB_STATS_EN
      ,
      .o_stat_cnt  (stat_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Producer i presents payload 0xA000_0000 + (beat<<8) + i while beats remain.
   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i]          = (rem[i] > 0);
         req_data[i*DW +: DW]  = 32'hA000_0000 + 32'(sent[i] << 8) + 32'(i);
      end
   endtask

   task automatic clear_prod();
      for (int i = 0; i < NUM_REQ; i++) begin
         rem[i]  = 0;
         sent[i] = 0;
      end
   endtask

   // One clock cycle: drive, check outputs, let producers see ready, advance.
   task automatic step(input string tag, input logic eb, input logic [1:0] egid,
                       input logic ewr, input logic [31:0] edata, input logic [3:0] erdy);
      drive();
      @(negedge clk);
      chk({tag, ".busy"},  32'(busy),      32'(eb));
      chk({tag, ".gid"},   32'(grant_id),  32'(egid));
      chk({tag, ".wr"},    32'(fifo_wr),   32'(ewr));
      chk({tag, ".data"},  fifo_data,      edata);
      chk({tag, ".ready"}, 32'(req_ready), 32'(erdy));
      if (fifo_wr) wr_count++;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            sent[i]++;
            rem[i]--;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b0;
      fifo_full = 1'b0;
      req_valid = '0;
      req_data  = '0;
      clear_prod();
      @(posedge clk);
      @(posedge clk);
      #1;

      // Reset state
      step("rst", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
      rst = 1'b1;

      // T1: requester 2 alone, 6 beats -> 4-beat burst, bubble, 2 beats, drop
      wr_mark = wr_count;
      rem[2] = 6;
      step("t1_bub0", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
      for (int k = 0; k < 4; k++)
         step("t1_beat", 1'b1, 2'd2, 1'b1, 32'hA000_0002 + 32'(k << 8), 4'b0100);
      step("t1_bub1", 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000);
      step("t1_beat4", 1'b1, 2'd2, 1'b1, 32'hA000_0402, 4'b0100);
      step("t1_beat5", 1'b1, 2'd2, 1'b1, 32'hA000_0502, 4'b0100);
      step("t1_drop", 1'b1, 2'd2, 1'b0, 32'hA000_0602, 4'b0000);
      chk("t1_writes", 32'(wr_count - wr_mark), 32'd6);

      // T1b: rr_ptr is now 3; requester 3 sends 2 beats and drops, then 0
      rem[0] = 1;
      rem[3] = 2;
      step("t1b_idle", 1'b0, 2'd2, 1'b0, 32'h0, 4'b0000);
      step("t1b_r3b0", 1'b1, 2'd3, 1'b1, 32'hA000_0003, 4'b1000);
      step("t1b_r3b1", 1'b1, 2'd3, 1'b1, 32'hA000_0103, 4'b1000);
      step("t1b_r3drop", 1'b1, 2'd3, 1'b0, 32'hA000_0203, 4'b0000);
      step("t1b_idle2", 1'b0, 2'd3, 1'b0, 32'h0, 4'b0000);
      step("t1b_r0b0", 1'b1, 2'd0, 1'b1, 32'hA000_0000, 4'b0001);
      step("t1b_r0drop", 1'b1, 2'd0, 1'b0, 32'hA000_0100, 4'b0000);
      step("t1b_quiet", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);

      // T2: reset (rr_ptr was 1), then all four valid for two rounds
      rst = 1'b0;
      step("t2_rst", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
      rst = 1'b1;
      clear_prod();
      for (int i = 0; i < NUM_REQ; i++) rem[i] = 8;
      wr_mark = wr_count;
      for (int b = 0; b < 8; b++) begin
         step("t2_bubble", 1'b0, (b == 0) ? 2'd0 : 2'((b - 1) % 4), 1'b0, 32'h0, 4'b0000);
         for (int k = 0; k < 4; k++)
            step("t2_beat", 1'b1, 2'(b % 4), 1'b1,
                 32'hA000_0000 + 32'((((b / 4) * 4) + k) << 8) + 32'(b % 4),
                 4'(1 << (b % 4)));
      end
      step("t2_end", 1'b0, 2'd3, 1'b0, 32'h0, 4'b0000);
      chk("t2_writes", 32'(wr_count - wr_mark), 32'd32);

      // T3: fifo_full for 3 cycles mid-burst of requester 1
      clear_prod();
      rem[1] = 4;
      wr_mark = wr_count;
      step("t3_bub", 1'b0, 2'd3, 1'b0, 32'h0, 4'b0000);
      step("t3_b0", 1'b1, 2'd1, 1'b1, 32'hA000_0001, 4'b0010);
      step("t3_b1", 1'b1, 2'd1, 1'b1, 32'hA000_0101, 4'b0010);
      fifo_full = 1'b1;
      for (int k = 0; k < 3; k++)
         step("t3_full", 1'b1, 2'd1, 1'b0, 32'hA000_0201, 4'b0000);
      fifo_full = 1'b0;
      step("t3_b2", 1'b1, 2'd1, 1'b1, 32'hA000_0201, 4'b0010);
      step("t3_b3", 1'b1, 2'd1, 1'b1, 32'hA000_0301, 4'b0010);
      step("t3_end", 1'b0, 2'd1, 1'b0, 32'h0, 4'b0000);
      chk("t3_writes", 32'(wr_count - wr_mark), 32'd4);
`ifdef FIFO_ARB_STATS_EN
      chk("stat0_a", 32'(stat_cnt[15:0]),  32'd8);
      chk("stat1_a", 32'(stat_cnt[31:16]), 32'd12);
      chk("stat2_a", 32'(stat_cnt[47:32]), 32'd8);
      chk("stat3_a", 32'(stat_cnt[63:48]), 32'd8);
`endif

      // T5: reset during the 2nd beat of requester 3 (rr_ptr was 2)
      clear_prod();
      rem[3] = 4;
      step("t5_bub", 1'b0, 2'd1, 1'b0, 32'h0, 4'b0000);
      step("t5_b0", 1'b1, 2'd3, 1'b1, 32'hA000_0003, 4'b1000);
      rst = 1'b0;
      step("t5_b1_rst", 1'b1, 2'd3, 1'b1, 32'hA000_0103, 4'b1000);
      rst = 1'b1;
      rem[0] = 1;
      step("t5_after_rst", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
      step("t5_r0", 1'b1, 2'd0, 1'b1, 32'hA000_0000, 4'b0001);
      step("t5_r0drop", 1'b1, 2'd0, 1'b0, 32'hA000_0100, 4'b0000);
      step("t5_bub2", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
      step("t5_r3b2", 1'b1, 2'd3, 1'b1, 32'hA000_0203, 4'b1000);
      step("t5_r3b3", 1'b1, 2'd3, 1'b1, 32'hA000_0303, 4'b1000);
      step("t5_r3drop", 1'b1, 2'd3, 1'b0, 32'hA000_0403, 4'b0000);
      step("t5_end", 1'b0, 2'd3, 1'b0, 32'h0, 4'b0000);
`ifdef FIFO_ARB_STATS_EN
      chk("stat0_b", 32'(stat_cnt[15:0]),  32'd1);
      chk("stat1_b", 32'(stat_cnt[31:16]), 32'd0);
      chk("stat2_b", 32'(stat_cnt[47:32]), 32'd0);
      chk("stat3_b", 32'(stat_cnt[63:48]), 32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
